// File: rtl/iolab_bus_pkg.sv
// Shared encodings for the bus read-return path: FSM states, latched source kind, counter width.
package iolab_bus_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERRW = 2'd2,
    RESP = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SRC_MEM  = 2'd0,
    SRC_IO   = 2'd1,
    SRC_NONE = 2'd2
  } src_e;

  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/io_sel_prienc.sv
// Priority encoder over active-low IO chip selects; the lowest asserted index wins.
module io_sel_prienc #(
  parameter int unsigned N_IO  = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_IO-1:0]  cs_n_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

  // Scan from the top down so the lowest asserted select is the last to write.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int k = int'(N_IO) - 1; k >= 0; k--) begin
      if (!cs_n_i[k]) begin
        found_o = 1'b1;
        idx_o   = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/wb_rd_mux_ws.sv
// Registered read-data return path: selects memory or one IO port, inserts wait states,
// and returns the word with a one-cycle ack (or a one-cycle err for an unselected IO read).
module wb_rd_mux_ws
  import iolab_bus_pkg::*;
#(
  parameter int unsigned DW       = 16,
  parameter int unsigned N_IO     = 4,
  parameter int unsigned MEM_WAIT = 1,
  parameter int unsigned IO_WAIT  = 2,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  input  logic               wb_we_i,
  input  logic               wb_tga_i,
  input  logic [DW-1:0]      mem_dat_i,
  input  logic [N_IO-1:0]    io_cs_n_i,
  input  logic [N_IO*DW-1:0] io_dat_i,
  output logic [DW-1:0]      wb_dat_o,
  output logic               wb_ack_o,
  output logic               wb_err_o,
  output logic               busy_o
);

  localparam int unsigned IDX_W = idx_width(N_IO);

  state_e             state_q, state_d;
  src_e               src_q, src_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]      dat_q, dat_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;

  logic               req;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_found;
  logic [DW-1:0]      src_dat;

  assign req = wb_cyc_i & wb_stb_i & ~wb_we_i;

  io_sel_prienc #(
    .N_IO  (N_IO),
    .IDX_W (IDX_W)
  ) u_sel (
    .cs_n_i  (io_cs_n_i),
    .idx_o   (sel_idx),
    .found_o (sel_found)
  );

  // N_IO+1:1 mux driven by the source latched at request time, not the live selects.
  always_comb begin
    src_dat = mem_dat_i;
    if (src_q == SRC_IO) begin
      src_dat = '0;
      for (int k = 0; k < int'(N_IO); k++) begin
        if (idx_q == IDX_W'(k)) src_dat = io_dat_i[k*DW +: DW];
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req) state_d = (!wb_tga_i || sel_found) ? WAIT : ERRW;
      WAIT, ERRW: begin
        if (!wb_cyc_i)       state_d = IDLE;
        else if (cnt_q == '0) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values; dat/ack/err default to 0 so the outputs clear on leaving RESP.
  always_comb begin
    src_d = src_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    dat_d = '0;
    ack_d = 1'b0;
    err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          idx_d = sel_idx;
          if (!wb_tga_i) begin
            src_d = SRC_MEM;
            cnt_d = CNT_W'(MEM_WAIT);
          end else if (sel_found) begin
            src_d = SRC_IO;
            cnt_d = CNT_W'(IO_WAIT);
          end else begin
            src_d = SRC_NONE;
            cnt_d = CNT_W'(TIMEOUT - 1);
          end
        end
      end
      WAIT, ERRW: begin
        if (!wb_cyc_i) begin
          cnt_d = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (state_q == WAIT) begin
          dat_d = src_dat;
          ack_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      src_q <= SRC_MEM;
      idx_q <= '0;
      cnt_q <= '0;
      dat_q <= '0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      src_q <= src_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      dat_q <= dat_d;
      ack_q <= ack_d;
      err_q <= err_d;
    end
  end

  assign wb_dat_o = dat_q;
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign busy_o   = (state_q != IDLE);

endmodule

// File: tb/tb_wb_rd_mux_ws.sv
// Directed bench for wb_rd_mux_ws: a vector table for single reads plus hand sequences
// for data sampling time, chip-select changes, abort, reset and back-to-back requests.
module tb_wb_rd_mux_ws;

  localparam int DW   = 16;
  localparam int N_IO = 4;

  logic               clk;
  logic               rst;
  logic               cyc, stb, we, tga;
  logic [DW-1:0]      mem_dat;
  logic [N_IO-1:0]    cs_n;
  logic [N_IO*DW-1:0] io_dat;

  logic [DW-1:0] dat,  dat0;
  logic          ack,  ack0;
  logic          err,  err0;
  logic          busy, busy0;

  // Default timing: MEM_WAIT=1, IO_WAIT=2, TIMEOUT=15.
  wb_rd_mux_ws #(.DW(DW), .N_IO(N_IO), .MEM_WAIT(1), .IO_WAIT(2), .TIMEOUT(15)) u_dut (
    .wb_clk_i (clk), .wb_rst_i (rst), .wb_cyc_i (cyc), .wb_stb_i (stb),
    .wb_we_i (we), .wb_tga_i (tga), .mem_dat_i (mem_dat), .io_cs_n_i (cs_n),
    .io_dat_i (io_dat), .wb_dat_o (dat), .wb_ack_o (ack), .wb_err_o (err), .busy_o (busy)
  );

  // Boundary timing: zero wait states and the shortest timeout.
  wb_rd_mux_ws #(.DW(DW), .N_IO(N_IO), .MEM_WAIT(0), .IO_WAIT(0), .TIMEOUT(1)) u_dut0 (
    .wb_clk_i (clk), .wb_rst_i (rst), .wb_cyc_i (cyc), .wb_stb_i (stb),
    .wb_we_i (we), .wb_tga_i (tga), .mem_dat_i (mem_dat), .io_cs_n_i (cs_n),
    .io_dat_i (io_dat), .wb_dat_o (dat0), .wb_ack_o (ack0), .wb_err_o (err0), .busy_o (busy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Advance one rising edge and land on the following falling edge for sampling/driving.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  localparam logic [N_IO*DW-1:0] IO_D = {16'h3333, 16'h2222, 16'h1111, 16'h0F0F};

  // kind: 0 = no response, 1 = ack, 2 = err. lat counts edges after the request edge.
  typedef struct {
    logic        cyc, stb, we, tga;
    logic [15:0] mem;
    logic [3:0]  cs;
    int          kind;
    int          lat;
    int          lat0;
    logic [15:0] dat;
  } vec_t;

  vec_t vecs[10];

  task automatic idle_bus();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; tga = 1'b0;
    mem_dat = '0; cs_n = 4'b1111; io_dat = IO_D;
  endtask

  int          ev_i, ev0_i, n_ack, n_err, ack_i2;
  logic [15:0] ev_dat, ev2_dat;
  bit          bad;

  initial begin
    idle_bus();
    rst = 1'b1;

    //          cyc   stb   we    tga   mem       cs       kind lat lat0 dat
    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'hA5A5, 4'b1111, 1,  2,  1, 16'hA5A5};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 4'b1001, 1,  3,  1, 16'h1111};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 4'b1111, 2, 15,  1, 16'h0000};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'hBEEF, 4'b1111, 0, -1, -1, 16'h0000};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 4'b0111, 1,  3,  1, 16'h3333};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 4'b1110, 1,  3,  1, 16'h0F0F};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 4'b1110, 0, -1, -1, 16'h0000};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFF, 4'b1111, 1,  2,  1, 16'hFFFF};
    vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 4'b1110, 0, -1, -1, 16'h0000};
    vecs[9] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h1234, 4'b1110, 0, -1, -1, 16'h0000};

    @(negedge clk);
    step();
    step();
    check("reset dat",  int'(dat),  0);
    check("reset ack",  int'(ack),  0);
    check("reset err",  int'(err),  0);
    check("reset busy", int'(busy), 0);
    rst = 1'b0;
    step();

    // ---- table-driven single accesses ----
    for (int vi = 0; vi < 10; vi++) begin
      cyc = vecs[vi].cyc; stb = vecs[vi].stb; we = vecs[vi].we; tga = vecs[vi].tga;
      mem_dat = vecs[vi].mem; cs_n = vecs[vi].cs;
      ev_i = -1; ev0_i = -1; n_ack = 0; n_err = 0; ev_dat = '0; bad = 1'b0;
      for (int i = 0; i < 25; i++) begin
        step();
        if (i == 0) stb = 1'b0;
        if ((ack || err) && ev_i < 0) begin ev_i = i; ev_dat = dat; end
        if ((ack0 || err0) && ev0_i < 0) ev0_i = i;
        n_ack += int'(ack);
        n_err += int'(err);
        if (!ack && dat != '0) bad = 1'b1;
        if (ack && err) bad = 1'b1;
      end
      check($sformatf("v%0d latency", vi), ev_i, vecs[vi].lat);
      check($sformatf("v%0d ack count", vi), n_ack, (vecs[vi].kind == 1) ? 1 : 0);
      check($sformatf("v%0d err count", vi), n_err, (vecs[vi].kind == 2) ? 1 : 0);
      check($sformatf("v%0d data", vi), int'(ev_dat), int'(vecs[vi].dat));
      check($sformatf("v%0d dat zero off-ack", vi), int'(bad), 0);
      check($sformatf("v%0d zero-wait latency", vi), ev0_i, vecs[vi].lat0);
      check($sformatf("v%0d idle after", vi), int'(busy), 0);
      idle_bus();
      step();
    end

    // ---- memory data is sampled at the final wait edge, not at request ----
    cyc = 1'b1; stb = 1'b1; tga = 1'b0; mem_dat = 16'hA5A5;
    step();
    stb = 1'b0; mem_dat = 16'h5A5A;
    step();
    check("late sample ack before", int'(ack), 0);
    step();
    check("late sample ack", int'(ack), 1);
    check("late sample data", int'(dat), 16'h5A5A);
    step();
    check("late sample ack drop", int'(ack), 0);
    check("late sample data clear", int'(dat), 0);
    idle_bus();
    step();

    // ---- chip select moves to port 2 during wait: port 1 still returned ----
    cyc = 1'b1; stb = 1'b1; tga = 1'b1; cs_n = 4'b1001;
    step();
    stb = 1'b0; cs_n = 4'b1011;
    step();
    step();
    check("cs move no early ack", int'(ack), 0);
    step();
    check("cs move ack", int'(ack), 1);
    check("cs move data", int'(dat), 16'h1111);
    idle_bus();
    step();

    // ---- chip select arriving during ERRW does not rescue the access ----
    cyc = 1'b1; stb = 1'b1; tga = 1'b1; cs_n = 4'b1111;
    step();
    stb = 1'b0; cs_n = 4'b1110;
    ev_i = -1; n_ack = 0;
    for (int i = 1; i < 20; i++) begin
      step();
      if (err && ev_i < 0) ev_i = i;
      n_ack += int'(ack);
    end
    check("errw rescue err latency", ev_i, 15);
    check("errw rescue no ack", n_ack, 0);
    idle_bus();
    step();

    // ---- abort by dropping cyc, then a fresh read completes ----
    cyc = 1'b1; stb = 1'b1; tga = 1'b1; cs_n = 4'b1110;
    step();
    cyc = 1'b0; stb = 1'b0;
    ev_i = -1; n_ack = 0; n_err = 0; ev_dat = '0;
    for (int i = 1; i < 12; i++) begin
      step();
      if (i == 1) check("abort busy", int'(busy), 0);
      if (i == 2) begin
        cyc = 1'b1; stb = 1'b1; tga = 1'b0; mem_dat = 16'h1234;
      end
      if (i == 3) stb = 1'b0;
      if (ack && ev_i < 0) begin ev_i = i; ev_dat = dat; end
      n_ack += int'(ack);
      n_err += int'(err);
    end
    check("abort then read ack cycle", ev_i, 5);
    check("abort then read ack count", n_ack, 1);
    check("abort then read err count", n_err, 0);
    check("abort then read data", int'(ev_dat), 16'h1234);
    idle_bus();
    step();

    // ---- reset pulsed during WAIT ----
    cyc = 1'b1; stb = 1'b1; tga = 1'b1; cs_n = 4'b1101;
    step();
    stb = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid reset outputs", int'({dat, ack, err}), 0);
    check("mid reset busy", int'(busy), 0);
    n_ack = 0; n_err = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      n_ack += int'(ack);
      n_err += int'(err);
    end
    check("post reset no ack", n_ack, 0);
    check("post reset no err", n_err, 0);
    idle_bus();
    step();

    // ---- back-to-back: stb held through the ack ----
    cyc = 1'b1; stb = 1'b1; tga = 1'b0; mem_dat = 16'hC3C3;
    ev_i = -1; ack_i2 = -1; ev2_dat = '0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (ack) begin
        if (ev_i < 0) ev_i = i;
        else if (ack_i2 < 0) begin ack_i2 = i; ev2_dat = dat; end
      end
    end
    check("b2b first ack", ev_i, 2);
    check("b2b second ack", ack_i2, 6);
    check("b2b second data", int'(ev2_dat), 16'hC3C3);
    idle_bus();
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
